// File: rtl/fractal_sync_req_arbiter.sv
// Round-robin arbiter sharing one fractal-sync master port between N_REQ local requesters.
// Only one barrier is in flight at a time: accept, sync pulse, wait for wake/error, respond.
module fractal_sync_req_arbiter #(
   parameter int unsigned N_REQ       = 2,
   parameter int unsigned AGGR_W      = 8,
   parameter int unsigned ID_W        = 8,
   parameter int unsigned TIMEOUT_W   = 16,
   parameter int unsigned TIMEOUT_CYC = 0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   input  logic [N_REQ-1:0]         req_valid_i,
   output logic [N_REQ-1:0]         req_ready_o,
   input  logic [N_REQ*AGGR_W-1:0]  req_aggr_i,
   input  logic [N_REQ*ID_W-1:0]    req_id_i,
   output logic [N_REQ-1:0]         rsp_valid_o,
   output logic                     rsp_error_o,
   output logic                     rsp_timeout_o,
   output logic                     fsync_sync_o,
   output logic [AGGR_W-1:0]        fsync_aggr_o,
   output logic [ID_W-1:0]          fsync_id_req_o,
   input  logic                     fsync_wake_i,
   input  logic                     fsync_error_i,
   output logic                     busy_o,
   output logic                     spurious_o,
   output logic [1:0]               state_o
);

   // Handshake: a requester holds req_valid_i and its aggr/id stable until it sees its
   // req_ready_o bit high for one cycle; that cycle is the accept. The single-cycle
   // rsp_valid_o pulse later returns completion, qualified by rsp_error_o/rsp_timeout_o.

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [TIMEOUT_W-1:0] TMO_LAST =
      TIMEOUT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]     grant_q, grant_d;
   logic [PTR_W-1:0]     gnt_idx;
   logic                 gnt_found;
   logic [AGGR_W-1:0]    aggr_q, aggr_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic                 err_q, err_d;
   logic                 tmo_q, tmo_d;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   logic                 abort;

   assign abort = rst_i | clear_i;

   // First pending requester at or after the round-robin pointer, wrapping.
   always_comb begin : grant_search
      logic [PTR_W-1:0] cand;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = PTR_W'((32'(rr_ptr_q) + k) % N_REQ);
         if (!gnt_found && req_valid_i[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      grant_d        = grant_q;
      aggr_d         = aggr_q;
      id_d           = id_q;
      err_d          = err_q;
      tmo_d          = tmo_q;
      cnt_d          = cnt_q;
      req_ready_o    = '0;
      rsp_valid_o    = '0;
      rsp_error_o    = 1'b0;
      rsp_timeout_o  = 1'b0;
      fsync_sync_o   = 1'b0;
      fsync_aggr_o   = '0;
      fsync_id_req_o = '0;
      spurious_o     = 1'b0;

      case (state_q)
         IDLE: begin
            spurious_o = fsync_wake_i | fsync_error_i;
            if (gnt_found) begin
               req_ready_o[gnt_idx] = 1'b1;
               grant_d = gnt_idx;
               aggr_d  = req_aggr_i[32'(gnt_idx)*AGGR_W +: AGGR_W];
               id_d    = req_id_i[32'(gnt_idx)*ID_W +: ID_W];
               err_d   = 1'b0;
               tmo_d   = 1'b0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            fsync_sync_o   = 1'b1;
            fsync_aggr_o   = aggr_q;
            fsync_id_req_o = id_q;
            cnt_d          = '0;
            // The network may answer in the same cycle it sees the sync pulse.
            if (fsync_error_i) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else if (fsync_wake_i) begin
               state_d = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != {TIMEOUT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
            if (fsync_error_i) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else if (fsync_wake_i) begin
               state_d = RESP;
            end else if ((TIMEOUT_CYC != 0) && (cnt_q == TMO_LAST)) begin
               err_d   = 1'b1;
               tmo_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            spurious_o           = fsync_wake_i | fsync_error_i;
            rsp_valid_o[grant_q] = 1'b1;
            rsp_error_o          = err_q;
            rsp_timeout_o        = tmo_q;
            rr_ptr_d             = PTR_W'((32'(grant_q) + 32'd1) % N_REQ);
            cnt_d                = '0;
            state_d              = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // An abort drops whatever is in flight, including a pending accept or response.
      if (abort) begin
         req_ready_o    = '0;
         rsp_valid_o    = '0;
         rsp_error_o    = 1'b0;
         rsp_timeout_o  = 1'b0;
         fsync_sync_o   = 1'b0;
         fsync_aggr_o   = '0;
         fsync_id_req_o = '0;
         spurious_o     = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (abort) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         aggr_q   <= '0;
         id_q     <= '0;
         err_q    <= 1'b0;
         tmo_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         aggr_q   <= aggr_d;
         id_q     <= id_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy_o  = (state_q != IDLE);
   assign state_o = state_q;

endmodule
